mvu_cfg_interface: RTL and testbench
====================================

Name: mvu_cfg_interface

Overview:
APB slave register bank that holds the per-MVU configuration for all NMVU matrix-vector units in mvu_top.
It decodes APB writes into per-MVU config registers and emits a one-cycle start pulse per MVU when that MVU's COMMAND CSR is written.
It sits between the host APB bus and the MVU array config inputs.

Parameters:
NMVU, 8, number of MVUs.
BMVUA, 3, MVU-select field width; paddr[APB_ADDR_WIDTH-1:12].
APB_ADDR_WIDTH, 15, equals BMVUA+12.
APB_DATA_WIDTH, 32.
BBWADDR, 9, weight base address width.
BBDADDR, 15, data/input/output/HP base address width.
BSBANKA, 6, scaler bank address width.
BBBANKA, 6, bias bank address width.
BJUMP, 15, jump width; also used for HP lengths.
BLENGTH, 15, length width.
BPREC, 6, precision field width.
BCNTDWN, 29, countdown width.
BQMSBIDX, 5, quantizer MSB index width.
BSCALERB, 16, scaler width.
NJUMPS, 5, number of jump levels.

Ports:
clk  in  1  clock.
rst_n  in  1  async active-low reset.
psel, penable, pwrite  in  1 each  APB control.
paddr  in  APB_ADDR_WIDTH  APB address; [11:0] is CSR offset, upper bits are mvu_id.
pwdata  in  32  APB write data.
pready  out  1  tied 1.
pslverr  out  1  tied 0.
start  out  NMVU  per-MVU start pulse.
wbaseaddr, ibaseaddr, obaseaddr, ihpbaseaddr, ohpbaseaddr  out  [NMVU] x base width  base addresses.
sbaseaddr, bbaseaddr  out  [NMVU] x bank width  scaler/bias bank addresses.
wjump, ijump, sjump, bjump, ojump, hpjump  out  [NMVU][NJUMPS] x BJUMP  jump strides.
wlength, ilength, slength, blength, olength  out  [NMVU][NJUMPS] x BLENGTH  loop lengths.
hplength  out  [NMVU][NJUMPS] x BJUMP  HP loop lengths.
wprecision, iprecision, oprecision  out  [NMVU] x BPREC  precisions.
w_signed, d_signed, max_en, max_clr, max_pool, quant_clr  out  [NMVU] x 1  mode flags.
countdown  out  [NMVU] x BCNTDWN  countdown.
mul_mode  out  [NMVU] x 2  multiply mode.
quant_msbidx  out  [NMVU] x BQMSBIDX  quantizer MSB index.
scaler_b  out  [NMVU] x BSCALERB  scaler.
shacc_load_sel, zigzag_step_sel  out  [NMVU] x NJUMPS  level selects.
omvusel, ohpmvusel  out  [NMVU] x NMVU  output MVU selects.
usescaler_mem, usebias_mem, usepooler4hpout, usehpadder  out  [NMVU] x 1  enables.

Behaviour:
- Write strobe: wr = psel & penable & pwrite. pready = 1, so every access completes in one cycle. Reads return 0 unless the optional feature is enabled.
- On the rising clk edge with wr: the field of MVU mvu_id selected by paddr[11:0] loads the low bits of pwdata. All config outputs are flops and hold their value between writes.
- Ignored writes: mvu_id >= NMVU, unmapped offsets, and STATUS.
- CSR offsets (enum mvu_csr_t):
  - 0xF20..0xF24: W/I/S/B/OBASEPTR.
  - 0xF25-29 WJUMP_0..4; 0xF2A-2E IJUMP; 0xF2F-33 SJUMP; 0xF34-38 BJUMP; 0xF39-3D OJUMP.
  - 0xF3E-41 WLENGTH_1..4; 0xF42-45 ILENGTH; 0xF46-49 SLENGTH; 0xF4A-4D BLENGTH; 0xF4E-51 OLENGTH. Each _k writes index k.
  - 0xF52 PRECISION: w=[5:0], i=[11:6], o=[17:12], w_signed=[24], d_signed=[25].
  - 0xF53 STATUS.
  - 0xF54 COMMAND: countdown=[28:0], max_en=[29], mul_mode=[31:30]; also clears max_clr, max_pool, quant_clr.
  - 0xF55 QUANT; 0xF56 SCALER; 0xF57 CONFIG1: shacc_load_sel=[4:0], zigzag_step_sel=[9:5].
  - 0xF58 OMVUSEL; 0xF59 IHPBASEADDR; 0xF5A OHPBASEADDR; 0xF5B OHPMVUSEL.
  - 0xF5C-60 HPJUMP_0..4; 0xF61-64 HPLENGTH_1..4.
  - 0xF65 USESCALER_MEM, 0xF66 USEBIAS_MEM, 0xF67 USEPOOLER4HPOUT, 0xF68 USEHPADDER; each takes bit [0].
- Length index 0 is never writable and reads 0.
- start[i] is registered: it is 1 in the cycle after the edge that captured a COMMAND write to MVU i, else 0. The COMMAND fields are visible in that same cycle.
- Back-to-back COMMAND writes keep start[i] high on consecutive cycles.
- Reset (async, rst_n low): all outputs 0, start 0. Reset during a write discards that write.

Optional Feature:
MVU_CFG_READBACK_EN:
- Defined: adds port prdata (out, 32). When psel & ~pwrite, it combinationally returns the addressed field, zero-extended and packed at the same bit positions as on write. STATUS, unmapped offsets and invalid mvu_id return 0.
- Undefined: no prdata port.

Decomposition:
- mvu_pkg holds all width parameters, NMVU, NJUMPS and the mvu_csr_t enum with its offsets.
- One sub-module, mvu_cfg_bank: the register set of a single MVU, instantiated NMVU times with a per-instance write-enable.

Test Plan:
- Reset: assert rst_n=0 mid-run -> all outputs 0 immediately, start=0.
- Base write: paddr=0x2F20 (MVU2 WBASEPTR), pwdata=0x1AB -> wbaseaddr[2]=0x1AB next cycle; other MVUs unchanged.
- PRECISION write: pwdata=0x0300_2082 to MVU0 -> wprecision=2, iprecision=2, oprecision=2, w_signed=1, d_signed=1.
- COMMAND write: MVU5 with pwdata=0x6000_0010 -> countdown[5]=16, max_en=1, mul_mode=1; start=8'b0010_0000 for exactly one cycle.
- Length indexing: write SLENGTH_3 of MVU1 with 7 -> slength[1][3]=7, slength[1][1] unchanged.
- Ignored writes: write with psel=1, penable=0, or to mvu_id 9 (if BMVUA allows) -> no register change, start stays 0.

Source files
------------

// File: rtl/mvu_cfg_interface_pkg.sv
// Shared widths, MVU count and CSR offset map for the MVU configuration register bank.
// Optional readback (MVU_CFG_READBACK_EN) is handled in the interface, bank and top files.
package mvu_pkg;

    localparam int NMVU           = 8;
    localparam int BMVUA          = 3;
    localparam int APB_ADDR_WIDTH = BMVUA + 12;
    localparam int APB_DATA_WIDTH = 32;
    localparam int BBWADDR        = 9;
    localparam int BBDADDR        = 15;
    localparam int BSBANKA        = 6;
    localparam int BBBANKA        = 6;
    localparam int BJUMP          = 15;
    localparam int BLENGTH        = 15;
    localparam int BPREC          = 6;
    localparam int BCNTDWN        = 29;
    localparam int BQMSBIDX       = 5;
    localparam int BSCALERB       = 16;
    localparam int NJUMPS         = 5;

    // Array CSRs list only their first entry; the rest follow at consecutive offsets.
    typedef enum logic [11:0] {
        CSR_WBASEPTR        = 12'hF20,
        CSR_IBASEPTR        = 12'hF21,
        CSR_SBASEPTR        = 12'hF22,
        CSR_BBASEPTR        = 12'hF23,
        CSR_OBASEPTR        = 12'hF24,
        CSR_WJUMP_0         = 12'hF25,
        CSR_IJUMP_0         = 12'hF2A,
        CSR_SJUMP_0         = 12'hF2F,
        CSR_BJUMP_0         = 12'hF34,
        CSR_OJUMP_0         = 12'hF39,
        CSR_WLENGTH_1       = 12'hF3E,
        CSR_ILENGTH_1       = 12'hF42,
        CSR_SLENGTH_1       = 12'hF46,
        CSR_BLENGTH_1       = 12'hF4A,
        CSR_OLENGTH_1       = 12'hF4E,
        CSR_PRECISION       = 12'hF52,
        CSR_STATUS          = 12'hF53,
        CSR_COMMAND         = 12'hF54,
        CSR_QUANT           = 12'hF55,
        CSR_SCALER          = 12'hF56,
        CSR_CONFIG1         = 12'hF57,
        CSR_OMVUSEL         = 12'hF58,
        CSR_IHPBASEADDR     = 12'hF59,
        CSR_OHPBASEADDR     = 12'hF5A,
        CSR_OHPMVUSEL       = 12'hF5B,
        CSR_HPJUMP_0        = 12'hF5C,
        CSR_HPLENGTH_1      = 12'hF61,
        CSR_USESCALER_MEM   = 12'hF65,
        CSR_USEBIAS_MEM     = 12'hF66,
        CSR_USEPOOLER4HPOUT = 12'hF67,
        CSR_USEHPADDER      = 12'hF68
    } mvu_csr_t;

    typedef struct packed {
        logic [BBWADDR-1:0]              wbaseaddr;
        logic [BBDADDR-1:0]              ibaseaddr, obaseaddr, ihpbaseaddr, ohpbaseaddr;
        logic [BSBANKA-1:0]              sbaseaddr;
        logic [BBBANKA-1:0]              bbaseaddr;
        logic [NJUMPS-1:0][BJUMP-1:0]    wjump, ijump, sjump, bjump, ojump, hpjump, hplength;
        logic [NJUMPS-1:0][BLENGTH-1:0]  wlength, ilength, slength, blength, olength;
        logic [BPREC-1:0]                wprecision, iprecision, oprecision;
        logic                            w_signed, d_signed, max_en, max_clr, max_pool, quant_clr;
        logic [BCNTDWN-1:0]              countdown;
        logic [1:0]                      mul_mode;
        logic [BQMSBIDX-1:0]             quant_msbidx;
        logic [BSCALERB-1:0]             scaler_b;
        logic [NJUMPS-1:0]               shacc_load_sel, zigzag_step_sel;
        logic [NMVU-1:0]                 omvusel, ohpmvusel;
        logic                            usescaler_mem, usebias_mem, usepooler4hpout, usehpadder;
    } mvu_cfg_t;

    function automatic logic [11:0] csr_at(mvu_csr_t base, int k);
        return 12'(base) + 12'(k);
    endfunction

endpackage

// File: rtl/mvu_cfg_interface_if.sv
// APB bus bundle for the MVU config bank; prdata exists only with MVU_CFG_READBACK_EN.
interface mvu_cfg_interface_if;
    import mvu_pkg::*;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pready;
    logic                      pslverr;
`ifdef MVU_CFG_READBACK_EN
    logic [APB_DATA_WIDTH-1:0] prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input pready, pslverr, prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, pslverr, prdata);
`else
    modport master (output psel, penable, pwrite, paddr, pwdata, input pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, pslverr);
`endif

endinterface

// File: rtl/mvu_cfg_interface_bank.sv
// Register set of one MVU: decodes CSR writes into config flops and a registered start pulse.
// MVU_CFG_READBACK_EN adds a combinational readback of the addressed field.
module mvu_cfg_bank
    import mvu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [11:0]               offset,
    input  logic [APB_DATA_WIDTH-1:0] wdata,
    output logic                      start,
    output mvu_cfg_t                  cfg
`ifdef MVU_CFG_READBACK_EN
    ,
    output logic [APB_DATA_WIDTH-1:0] rdata
`endif
);

    mvu_cfg_t cfg_q, cfg_d;
    logic     start_q, start_d;
    logic     unused_wdata_bits;

    assign unused_wdata_bits = ^wdata;

    always_comb begin
        cfg_d   = cfg_q;
        start_d = 1'b0;
        if (we) begin
            case (offset)
                CSR_WBASEPTR:        cfg_d.wbaseaddr   = wdata[BBWADDR-1:0];
                CSR_IBASEPTR:        cfg_d.ibaseaddr   = wdata[BBDADDR-1:0];
                CSR_SBASEPTR:        cfg_d.sbaseaddr   = wdata[BSBANKA-1:0];
                CSR_BBASEPTR:        cfg_d.bbaseaddr   = wdata[BBBANKA-1:0];
                CSR_OBASEPTR:        cfg_d.obaseaddr   = wdata[BBDADDR-1:0];
                CSR_PRECISION: begin
                    cfg_d.wprecision = wdata[BPREC-1:0];
                    cfg_d.iprecision = wdata[2*BPREC-1:BPREC];
                    cfg_d.oprecision = wdata[3*BPREC-1:2*BPREC];
                    cfg_d.w_signed   = wdata[24];
                    cfg_d.d_signed   = wdata[25];
                end
                // A new command also rearms the pooling/quantizer clear flags.
                CSR_COMMAND: begin
                    cfg_d.countdown = wdata[BCNTDWN-1:0];
                    cfg_d.max_en    = wdata[29];
                    cfg_d.mul_mode  = wdata[31:30];
                    cfg_d.max_clr   = 1'b0;
                    cfg_d.max_pool  = 1'b0;
                    cfg_d.quant_clr = 1'b0;
                    start_d         = 1'b1;
                end
                CSR_QUANT:           cfg_d.quant_msbidx = wdata[BQMSBIDX-1:0];
                CSR_SCALER:          cfg_d.scaler_b     = wdata[BSCALERB-1:0];
                CSR_CONFIG1: begin
                    cfg_d.shacc_load_sel  = wdata[NJUMPS-1:0];
                    cfg_d.zigzag_step_sel = wdata[2*NJUMPS-1:NJUMPS];
                end
                CSR_OMVUSEL:         cfg_d.omvusel         = wdata[NMVU-1:0];
                CSR_IHPBASEADDR:     cfg_d.ihpbaseaddr     = wdata[BBDADDR-1:0];
                CSR_OHPBASEADDR:     cfg_d.ohpbaseaddr     = wdata[BBDADDR-1:0];
                CSR_OHPMVUSEL:       cfg_d.ohpmvusel       = wdata[NMVU-1:0];
                CSR_USESCALER_MEM:   cfg_d.usescaler_mem   = wdata[0];
                CSR_USEBIAS_MEM:     cfg_d.usebias_mem     = wdata[0];
                CSR_USEPOOLER4HPOUT: cfg_d.usepooler4hpout = wdata[0];
                CSR_USEHPADDER:      cfg_d.usehpadder      = wdata[0];
                default: ;
            endcase
            // Length entry 0 has no CSR, so it stays at its reset value of 0.
            for (int k = 0; k < NJUMPS; k++) begin
                if (offset == csr_at(CSR_WJUMP_0, k))  cfg_d.wjump[k]  = wdata[BJUMP-1:0];
                if (offset == csr_at(CSR_IJUMP_0, k))  cfg_d.ijump[k]  = wdata[BJUMP-1:0];
                if (offset == csr_at(CSR_SJUMP_0, k))  cfg_d.sjump[k]  = wdata[BJUMP-1:0];
                if (offset == csr_at(CSR_BJUMP_0, k))  cfg_d.bjump[k]  = wdata[BJUMP-1:0];
                if (offset == csr_at(CSR_OJUMP_0, k))  cfg_d.ojump[k]  = wdata[BJUMP-1:0];
                if (offset == csr_at(CSR_HPJUMP_0, k)) cfg_d.hpjump[k] = wdata[BJUMP-1:0];
                if (k > 0) begin
                    if (offset == csr_at(CSR_WLENGTH_1, k - 1))  cfg_d.wlength[k]  = wdata[BLENGTH-1:0];
                    if (offset == csr_at(CSR_ILENGTH_1, k - 1))  cfg_d.ilength[k]  = wdata[BLENGTH-1:0];
                    if (offset == csr_at(CSR_SLENGTH_1, k - 1))  cfg_d.slength[k]  = wdata[BLENGTH-1:0];
                    if (offset == csr_at(CSR_BLENGTH_1, k - 1))  cfg_d.blength[k]  = wdata[BLENGTH-1:0];
                    if (offset == csr_at(CSR_OLENGTH_1, k - 1))  cfg_d.olength[k]  = wdata[BLENGTH-1:0];
                    if (offset == csr_at(CSR_HPLENGTH_1, k - 1)) cfg_d.hplength[k] = wdata[BJUMP-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            start_q <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            start_q <= start_d;
        end
    end

    assign cfg   = cfg_q;
    assign start = start_q;

`ifdef MVU_CFG_READBACK_EN
    always_comb begin
        rdata = '0;
        case (offset)
            CSR_WBASEPTR:        rdata = 32'(cfg_q.wbaseaddr);
            CSR_IBASEPTR:        rdata = 32'(cfg_q.ibaseaddr);
            CSR_SBASEPTR:        rdata = 32'(cfg_q.sbaseaddr);
            CSR_BBASEPTR:        rdata = 32'(cfg_q.bbaseaddr);
            CSR_OBASEPTR:        rdata = 32'(cfg_q.obaseaddr);
            CSR_PRECISION:       rdata = {6'b0, cfg_q.d_signed, cfg_q.w_signed, 6'b0,
                                          cfg_q.oprecision, cfg_q.iprecision, cfg_q.wprecision};
            CSR_COMMAND:         rdata = {cfg_q.mul_mode, cfg_q.max_en, cfg_q.countdown};
            CSR_QUANT:           rdata = 32'(cfg_q.quant_msbidx);
            CSR_SCALER:          rdata = 32'(cfg_q.scaler_b);
            CSR_CONFIG1:         rdata = 32'({cfg_q.zigzag_step_sel, cfg_q.shacc_load_sel});
            CSR_OMVUSEL:         rdata = 32'(cfg_q.omvusel);
            CSR_IHPBASEADDR:     rdata = 32'(cfg_q.ihpbaseaddr);
            CSR_OHPBASEADDR:     rdata = 32'(cfg_q.ohpbaseaddr);
            CSR_OHPMVUSEL:       rdata = 32'(cfg_q.ohpmvusel);
            CSR_USESCALER_MEM:   rdata = 32'(cfg_q.usescaler_mem);
            CSR_USEBIAS_MEM:     rdata = 32'(cfg_q.usebias_mem);
            CSR_USEPOOLER4HPOUT: rdata = 32'(cfg_q.usepooler4hpout);
            CSR_USEHPADDER:      rdata = 32'(cfg_q.usehpadder);
            default: ;
        endcase
        for (int k = 0; k < NJUMPS; k++) begin
            if (offset == csr_at(CSR_WJUMP_0, k))  rdata = 32'(cfg_q.wjump[k]);
            if (offset == csr_at(CSR_IJUMP_0, k))  rdata = 32'(cfg_q.ijump[k]);
            if (offset == csr_at(CSR_SJUMP_0, k))  rdata = 32'(cfg_q.sjump[k]);
            if (offset == csr_at(CSR_BJUMP_0, k))  rdata = 32'(cfg_q.bjump[k]);
            if (offset == csr_at(CSR_OJUMP_0, k))  rdata = 32'(cfg_q.ojump[k]);
            if (offset == csr_at(CSR_HPJUMP_0, k)) rdata = 32'(cfg_q.hpjump[k]);
            if (k > 0) begin
                if (offset == csr_at(CSR_WLENGTH_1, k - 1))  rdata = 32'(cfg_q.wlength[k]);
                if (offset == csr_at(CSR_ILENGTH_1, k - 1))  rdata = 32'(cfg_q.ilength[k]);
                if (offset == csr_at(CSR_SLENGTH_1, k - 1))  rdata = 32'(cfg_q.slength[k]);
                if (offset == csr_at(CSR_BLENGTH_1, k - 1))  rdata = 32'(cfg_q.blength[k]);
                if (offset == csr_at(CSR_OLENGTH_1, k - 1))  rdata = 32'(cfg_q.olength[k]);
                if (offset == csr_at(CSR_HPLENGTH_1, k - 1)) rdata = 32'(cfg_q.hplength[k]);
            end
        end
    end
`endif

endmodule

// File: rtl/mvu_cfg_interface.sv
// APB register bank holding the configuration of every MVU; paddr[14:12] picks the MVU.
// MVU_CFG_READBACK_EN enables combinational reads on the interface's prdata.
module mvu_cfg_interface
    import mvu_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    mvu_cfg_interface_if.slave             apb,
    output logic [NMVU-1:0]                start,
    output logic [BBWADDR-1:0]             wbaseaddr   [NMVU],
    output logic [BBDADDR-1:0]             ibaseaddr   [NMVU],
    output logic [BBDADDR-1:0]             obaseaddr   [NMVU],
    output logic [BBDADDR-1:0]             ihpbaseaddr [NMVU],
    output logic [BBDADDR-1:0]             ohpbaseaddr [NMVU],
    output logic [BSBANKA-1:0]             sbaseaddr   [NMVU],
    output logic [BBBANKA-1:0]             bbaseaddr   [NMVU],
    output logic [NJUMPS-1:0][BJUMP-1:0]   wjump       [NMVU],
    output logic [NJUMPS-1:0][BJUMP-1:0]   ijump       [NMVU],
    output logic [NJUMPS-1:0][BJUMP-1:0]   sjump       [NMVU],
    output logic [NJUMPS-1:0][BJUMP-1:0]   bjump       [NMVU],
    output logic [NJUMPS-1:0][BJUMP-1:0]   ojump       [NMVU],
    output logic [NJUMPS-1:0][BJUMP-1:0]   hpjump      [NMVU],
    output logic [NJUMPS-1:0][BLENGTH-1:0] wlength     [NMVU],
    output logic [NJUMPS-1:0][BLENGTH-1:0] ilength     [NMVU],
    output logic [NJUMPS-1:0][BLENGTH-1:0] slength     [NMVU],
    output logic [NJUMPS-1:0][BLENGTH-1:0] blength     [NMVU],
    output logic [NJUMPS-1:0][BLENGTH-1:0] olength     [NMVU],
    output logic [NJUMPS-1:0][BJUMP-1:0]   hplength    [NMVU],
    output logic [BPREC-1:0]               wprecision  [NMVU],
    output logic [BPREC-1:0]               iprecision  [NMVU],
    output logic [BPREC-1:0]               oprecision  [NMVU],
    output logic [NMVU-1:0]                w_signed,
    output logic [NMVU-1:0]                d_signed,
    output logic [NMVU-1:0]                max_en,
    output logic [NMVU-1:0]                max_clr,
    output logic [NMVU-1:0]                max_pool,
    output logic [NMVU-1:0]                quant_clr,
    output logic [BCNTDWN-1:0]             countdown   [NMVU],
    output logic [1:0]                     mul_mode    [NMVU],
    output logic [BQMSBIDX-1:0]            quant_msbidx[NMVU],
    output logic [BSCALERB-1:0]            scaler_b    [NMVU],
    output logic [NJUMPS-1:0]              shacc_load_sel [NMVU],
    output logic [NJUMPS-1:0]              zigzag_step_sel[NMVU],
    output logic [NMVU-1:0]                omvusel     [NMVU],
    output logic [NMVU-1:0]                ohpmvusel   [NMVU],
    output logic [NMVU-1:0]                usescaler_mem,
    output logic [NMVU-1:0]                usebias_mem,
    output logic [NMVU-1:0]                usepooler4hpout,
    output logic [NMVU-1:0]                usehpadder
);

    logic [BMVUA-1:0] mvu_id;
    logic [11:0]      csr_offset;
    logic             wr;
    logic             id_valid;
    mvu_cfg_t         cfg_w [NMVU];

    assign mvu_id      = apb.paddr[APB_ADDR_WIDTH-1:12];
    assign csr_offset  = apb.paddr[11:0];
    assign wr          = apb.psel & apb.penable & apb.pwrite;
    assign id_valid    = int'(mvu_id) < NMVU;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;

`ifdef MVU_CFG_READBACK_EN
    logic [APB_DATA_WIDTH-1:0] rdata_w [NMVU];

    assign apb.prdata = (apb.psel && !apb.pwrite && id_valid) ? rdata_w[mvu_id] : '0;
`endif

    for (genvar gi = 0; gi < NMVU; gi++) begin : g_mvu
        mvu_cfg_bank u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (wr && id_valid && (mvu_id == BMVUA'(gi))),
            .offset (csr_offset),
            .wdata  (apb.pwdata),
            .start  (start[gi]),
            .cfg    (cfg_w[gi])
`ifdef MVU_CFG_READBACK_EN
            ,
            .rdata  (rdata_w[gi])
`endif
        );

        assign wbaseaddr[gi]       = cfg_w[gi].wbaseaddr;
        assign ibaseaddr[gi]       = cfg_w[gi].ibaseaddr;
        assign obaseaddr[gi]       = cfg_w[gi].obaseaddr;
        assign ihpbaseaddr[gi]     = cfg_w[gi].ihpbaseaddr;
        assign ohpbaseaddr[gi]     = cfg_w[gi].ohpbaseaddr;
        assign sbaseaddr[gi]       = cfg_w[gi].sbaseaddr;
        assign bbaseaddr[gi]       = cfg_w[gi].bbaseaddr;
        assign wjump[gi]           = cfg_w[gi].wjump;
        assign ijump[gi]           = cfg_w[gi].ijump;
        assign sjump[gi]           = cfg_w[gi].sjump;
        assign bjump[gi]           = cfg_w[gi].bjump;
        assign ojump[gi]           = cfg_w[gi].ojump;
        assign hpjump[gi]          = cfg_w[gi].hpjump;
        assign wlength[gi]         = cfg_w[gi].wlength;
        assign ilength[gi]         = cfg_w[gi].ilength;
        assign slength[gi]         = cfg_w[gi].slength;
        assign blength[gi]         = cfg_w[gi].blength;
        assign olength[gi]         = cfg_w[gi].olength;
        assign hplength[gi]        = cfg_w[gi].hplength;
        assign wprecision[gi]      = cfg_w[gi].wprecision;
        assign iprecision[gi]      = cfg_w[gi].iprecision;
        assign oprecision[gi]      = cfg_w[gi].oprecision;
        assign w_signed[gi]        = cfg_w[gi].w_signed;
        assign d_signed[gi]        = cfg_w[gi].d_signed;
        assign max_en[gi]          = cfg_w[gi].max_en;
        assign max_clr[gi]         = cfg_w[gi].max_clr;
        assign max_pool[gi]        = cfg_w[gi].max_pool;
        assign quant_clr[gi]       = cfg_w[gi].quant_clr;
        assign countdown[gi]       = cfg_w[gi].countdown;
        assign mul_mode[gi]        = cfg_w[gi].mul_mode;
        assign quant_msbidx[gi]    = cfg_w[gi].quant_msbidx;
        assign scaler_b[gi]        = cfg_w[gi].scaler_b;
        assign shacc_load_sel[gi]  = cfg_w[gi].shacc_load_sel;
        assign zigzag_step_sel[gi] = cfg_w[gi].zigzag_step_sel;
        assign omvusel[gi]         = cfg_w[gi].omvusel;
        assign ohpmvusel[gi]       = cfg_w[gi].ohpmvusel;
        assign usescaler_mem[gi]   = cfg_w[gi].usescaler_mem;
        assign usebias_mem[gi]     = cfg_w[gi].usebias_mem;
        assign usepooler4hpout[gi] = cfg_w[gi].usepooler4hpout;
        assign usehpadder[gi]      = cfg_w[gi].usehpadder;
    end

endmodule

// File: tb/tb_mvu_cfg_interface.sv
// Directed bench for mvu_cfg_interface: expectations are queued with each access and
// checked at the falling edge after the capturing clock edge.
module tb_mvu_cfg_interface;
    import mvu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvu_cfg_interface_if apb ();

    logic [NMVU-1:0]                start;
    logic [BBWADDR-1:0]             wbaseaddr   [NMVU];
    logic [BBDADDR-1:0]             ibaseaddr   [NMVU];
    logic [BBDADDR-1:0]             obaseaddr   [NMVU];
    logic [BBDADDR-1:0]             ihpbaseaddr [NMVU];
    logic [BBDADDR-1:0]             ohpbaseaddr [NMVU];
    logic [BSBANKA-1:0]             sbaseaddr   [NMVU];
    logic [BBBANKA-1:0]             bbaseaddr   [NMVU];
    logic [NJUMPS-1:0][BJUMP-1:0]   wjump [NMVU], ijump [NMVU], sjump [NMVU];
    logic [NJUMPS-1:0][BJUMP-1:0]   bjump [NMVU], ojump [NMVU], hpjump [NMVU];
    logic [NJUMPS-1:0][BLENGTH-1:0] wlength [NMVU], ilength [NMVU], slength [NMVU];
    logic [NJUMPS-1:0][BLENGTH-1:0] blength [NMVU], olength [NMVU];
    logic [NJUMPS-1:0][BJUMP-1:0]   hplength [NMVU];
    logic [BPREC-1:0]               wprecision [NMVU], iprecision [NMVU], oprecision [NMVU];
    logic [NMVU-1:0]                w_signed, d_signed, max_en, max_clr, max_pool, quant_clr;
    logic [BCNTDWN-1:0]             countdown [NMVU];
    logic [1:0]                     mul_mode [NMVU];
    logic [BQMSBIDX-1:0]            quant_msbidx [NMVU];
    logic [BSCALERB-1:0]            scaler_b [NMVU];
    logic [NJUMPS-1:0]              shacc_load_sel [NMVU], zigzag_step_sel [NMVU];
    logic [NMVU-1:0]                omvusel [NMVU], ohpmvusel [NMVU];
    logic [NMVU-1:0]                usescaler_mem, usebias_mem, usepooler4hpout, usehpadder;

    mvu_cfg_interface dut (
        .clk(clk), .rst_n(rst_n), .apb(apb), .start(start),
        .wbaseaddr(wbaseaddr), .ibaseaddr(ibaseaddr), .obaseaddr(obaseaddr),
        .ihpbaseaddr(ihpbaseaddr), .ohpbaseaddr(ohpbaseaddr),
        .sbaseaddr(sbaseaddr), .bbaseaddr(bbaseaddr),
        .wjump(wjump), .ijump(ijump), .sjump(sjump), .bjump(bjump), .ojump(ojump), .hpjump(hpjump),
        .wlength(wlength), .ilength(ilength), .slength(slength), .blength(blength),
        .olength(olength), .hplength(hplength),
        .wprecision(wprecision), .iprecision(iprecision), .oprecision(oprecision),
        .w_signed(w_signed), .d_signed(d_signed), .max_en(max_en), .max_clr(max_clr),
        .max_pool(max_pool), .quant_clr(quant_clr), .countdown(countdown), .mul_mode(mul_mode),
        .quant_msbidx(quant_msbidx), .scaler_b(scaler_b),
        .shacc_load_sel(shacc_load_sel), .zigzag_step_sel(zigzag_step_sel),
        .omvusel(omvusel), .ohpmvusel(ohpmvusel),
        .usescaler_mem(usescaler_mem), .usebias_mem(usebias_mem),
        .usepooler4hpout(usepooler4hpout), .usehpadder(usehpadder)
    );

    typedef enum int {
        F_START, F_PREADY, F_PSLVERR, F_WBASE, F_WPREC, F_IPREC, F_OPREC, F_WSIGN, F_DSIGN,
        F_CNT, F_MAXEN, F_MULMODE, F_MAXCLR, F_SLEN, F_OJUMP, F_HPLEN, F_OHPSEL, F_USESCALER
    } fld_e;

    typedef struct {
        string       tag;
        fld_e        f;
        int          m;
        int          k;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(fld_e f, int m, int k);
        case (f)
            F_START:     return 32'(start);
            F_PREADY:    return 32'(apb.pready);
            F_PSLVERR:   return 32'(apb.pslverr);
            F_WBASE:     return 32'(wbaseaddr[m]);
            F_WPREC:     return 32'(wprecision[m]);
            F_IPREC:     return 32'(iprecision[m]);
            F_OPREC:     return 32'(oprecision[m]);
            F_WSIGN:     return 32'(w_signed[m]);
            F_DSIGN:     return 32'(d_signed[m]);
            F_CNT:       return 32'(countdown[m]);
            F_MAXEN:     return 32'(max_en[m]);
            F_MULMODE:   return 32'(mul_mode[m]);
            F_MAXCLR:    return 32'(max_clr[m]);
            F_SLEN:      return 32'(slength[m][k]);
            F_OJUMP:     return 32'(ojump[m][k]);
            F_HPLEN:     return 32'(hplength[m][k]);
            F_OHPSEL:    return 32'(ohpmvusel[m]);
            F_USESCALER: return 32'(usescaler_mem[m]);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(string tag, fld_e f, int m, int k, logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.f = f; e.m = m; e.k = k; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.f, e.m, e.k);
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
            end
            $display("check %s observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic bus_idle();
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    // Setup phase then access phase; returns on the falling edge after the capturing edge.
    task automatic apb_write(logic [APB_ADDR_WIDTH-1:0] a, logic [31:0] d);
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwdata = d;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        bus_idle();
    endtask

    initial begin
        bus_idle();
        apb.paddr = '0; apb.pwdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        push("rst_start", F_START, 0, 0, 32'h0);
        push("rst_wbase2", F_WBASE, 2, 0, 32'h0);
        push("rst_cnt5", F_CNT, 5, 0, 32'h0);
        push("rst_slen13", F_SLEN, 1, 3, 32'h0);
        push("pready", F_PREADY, 0, 0, 32'h1);
        push("pslverr", F_PSLVERR, 0, 0, 32'h0);
        drain();

        push("wbase2", F_WBASE, 2, 0, 32'h1AB);
        push("wbase1_keep", F_WBASE, 1, 0, 32'h0);
        push("wbase3_keep", F_WBASE, 3, 0, 32'h0);
        push("base_nostart", F_START, 0, 0, 32'h0);
        apb_write(15'h2F20, 32'h0000_01AB);
        drain();

        push("wprec0", F_WPREC, 0, 0, 32'h2);
        push("iprec0", F_IPREC, 0, 0, 32'h2);
        push("oprec0", F_OPREC, 0, 0, 32'h2);
        push("wsign0", F_WSIGN, 0, 0, 32'h1);
        push("dsign0", F_DSIGN, 0, 0, 32'h1);
        push("wprec1_keep", F_WPREC, 1, 0, 32'h0);
        apb_write(15'h0F52, 32'h0300_2082);
        drain();

        push("cmd_cnt5", F_CNT, 5, 0, 32'd16);
        push("cmd_maxen5", F_MAXEN, 5, 0, 32'h1);
        push("cmd_mul5", F_MULMODE, 5, 0, 32'h1);
        push("cmd_maxclr5", F_MAXCLR, 5, 0, 32'h0);
        push("cmd_start", F_START, 0, 0, 32'h20);
        push("cmd_wbase2_keep", F_WBASE, 2, 0, 32'h1AB);
        apb_write(15'h5F54, 32'h6000_0010);
        drain();
        @(negedge clk);
        push("cmd_start_drop", F_START, 0, 0, 32'h0);
        push("cmd_cnt5_hold", F_CNT, 5, 0, 32'd16);
        drain();

        // Access phase held across three edges: MVU3, MVU3, MVU4 commands back to back.
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b1;
        apb.paddr = 15'h3F54; apb.pwdata = 32'h0000_0003;
        @(negedge clk);
        push("b2b_start_a", F_START, 0, 0, 32'h08);
        push("b2b_cnt3", F_CNT, 3, 0, 32'd3);
        drain();
        apb.pwdata = 32'h0000_0007;
        @(negedge clk);
        push("b2b_start_b", F_START, 0, 0, 32'h08);
        push("b2b_cnt3_b", F_CNT, 3, 0, 32'd7);
        drain();
        apb.paddr = 15'h4F54; apb.pwdata = 32'h8000_0004;
        @(negedge clk);
        push("b2b_start_c", F_START, 0, 0, 32'h10);
        push("b2b_cnt4", F_CNT, 4, 0, 32'd4);
        push("b2b_mul4", F_MULMODE, 4, 0, 32'h2);
        push("b2b_maxen4", F_MAXEN, 4, 0, 32'h0);
        drain();
        bus_idle();
        @(negedge clk);
        push("b2b_start_end", F_START, 0, 0, 32'h0);
        drain();

        push("slen11", F_SLEN, 1, 1, 32'd5);
        apb_write(15'h1F46, 32'd5);
        drain();
        push("slen13", F_SLEN, 1, 3, 32'd7);
        push("slen11_keep", F_SLEN, 1, 1, 32'd5);
        push("slen10_zero", F_SLEN, 1, 0, 32'd0);
        push("slen03_keep", F_SLEN, 0, 3, 32'd0);
        apb_write(15'h1F48, 32'd7);
        drain();

        push("ojump64", F_OJUMP, 6, 4, 32'h7ABC);
        push("ojump63_keep", F_OJUMP, 6, 3, 32'h0);
        apb_write(15'h6F3D, 32'hFFFF_7ABC);
        drain();
        push("hplen74", F_HPLEN, 7, 4, 32'h1234);
        apb_write(15'h7F64, 32'h0000_1234);
        drain();
        push("usescaler7_b0", F_USESCALER, 7, 0, 32'h0);
        apb_write(15'h7F65, 32'hFFFF_FFFE);
        drain();
        push("usescaler7", F_USESCALER, 7, 0, 32'h1);
        apb_write(15'h7F65, 32'h0000_0003);
        drain();
        push("ohpsel0", F_OHPSEL, 0, 0, 32'hA5);
        apb_write(15'h0F5B, 32'h0000_01A5);
        drain();

        // Setup phase alone must not write.
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
        apb.paddr = 15'h2F20; apb.pwdata = 32'h0000_0055;
        @(negedge clk);
        bus_idle();
        push("nopen_wbase2", F_WBASE, 2, 0, 32'h1AB);
        push("nopen_start", F_START, 0, 0, 32'h0);
        drain();
        // Read access must not write or start.
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b1;
        apb.paddr = 15'h5F54; apb.pwdata = 32'h0000_0099;
        @(negedge clk);
        bus_idle();
        push("read_cnt5", F_CNT, 5, 0, 32'd16);
        push("read_start", F_START, 0, 0, 32'h0);
        drain();
        push("status_cnt5", F_CNT, 5, 0, 32'd16);
        push("status_wprec5", F_WPREC, 5, 0, 32'h0);
        push("status_start", F_START, 0, 0, 32'h0);
        apb_write(15'h5F53, 32'hFFFF_FFFF);
        drain();
        push("unmapped_wbase2", F_WBASE, 2, 0, 32'h1AB);
        apb_write(15'h2000, 32'h0000_0077);
        drain();

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        push("arst_wbase2", F_WBASE, 2, 0, 32'h0);
        push("arst_cnt5", F_CNT, 5, 0, 32'h0);
        push("arst_wprec0", F_WPREC, 0, 0, 32'h0);
        push("arst_ohpsel0", F_OHPSEL, 0, 0, 32'h0);
        push("arst_slen11", F_SLEN, 1, 1, 32'h0);
        push("arst_start", F_START, 0, 0, 32'h0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset held across the capturing edge discards the write.
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b1;
        apb.paddr = 15'h0F54; apb.pwdata = 32'h0000_0055;
        rst_n = 1'b0;
        @(negedge clk);
        bus_idle();
        rst_n = 1'b1;
        @(negedge clk);
        push("rstwr_cnt0", F_CNT, 0, 0, 32'h0);
        push("rstwr_start", F_START, 0, 0, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
